npu_seq: RTL and testbench
==========================

# npu_seq

Sequencer for the 3x3 weight-stationary systolic PE array. It streams up to 8 buffered 3-byte input vectors into the array's left edge with diagonal skew and drives the array enable. It captures each column's 16-bit result at the exact cycle it emerges from the bottom row, then signals completion. It sits between the Wishbone register block (vector load, start, result readback) and the PE array.

## Interface
- `VDEPTH`, 8: input vector buffer depth; max vectors per run.
- `IN_W`, 8: activation width.
- `ACC_W`, 16: result width (signed).
- `wb_clk_i`  in  1  sole clock; array and sequencer share it.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `vec_we`  in  1  write one vector into the buffer; ignored while `busy`.
- `vec_waddr`  in  3  vector buffer index.
- `vec_wdata`  in  24  `[7:0]`=x0 (row 1), `[15:8]`=x1 (row 2), `[23:16]`=x2 (row 3).
- `start`  in  1  launch a run; sampled only in IDLE.
- `nvec`  in  4  vectors per run; sampled with `start`.
- `busy`  out  1  high from the cycle after accepted `start` through DONE.
- `done`  out  1  one-cycle pulse in DONE.
- `arr_en`  out  1  PE array enable.
- `arr_in`  out  24  left-edge activations; byte r feeds row r+1.
- `arr_o`  in  48  bottom-row outputs; `[16j+15:16j]` is column j.
- `res_raddr`  in  5  result index = 3*k + j (vector k, column j).
- `res_rdata`  out  16  registered read; 1-cycle latency.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on `start` with `nvec`≠0.
  - RUN→DONE when `c` = N+4.
  - DONE→IDLE after one cycle.
- `nvec`=0 leaves the state at IDLE with no `done` pulse. `nvec`>8 clamps to N=8.
- Cycle counter `c` clears on entering RUN and increments each RUN cycle.
- Feed: byte r of `arr_in` = buffer[c−r] byte r when 0 ≤ c−r < N. Otherwise it is 0.
- `arr_en` = 1 throughout RUN and 0 in IDLE and DONE.
- Capture: in RUN, at counter value c, column j is written to result[3*(c−j−3)+j] when 0 ≤ c−j−3 < N. This gives the array latency of one cycle per PE hop plus one register stage.
- Up to 3 result writes occur per cycle, one per column, at distinct addresses.
- The result buffer holds 24 entries. Entries at or beyond 3N keep stale contents.
- `res_rdata` is readable in any state. During RUN it reflects partially updated data.
- `start` while `busy` is ignored. `vec_we` while `busy` is ignored.
- The vector buffer and result buffer are not reset.

## Timing
- Reset values: `busy`=0, `done`=0, `arr_en`=0, `arr_in`=0, `res_rdata`=0. State = IDLE. `c`=0.
- `start` at edge T gives RUN at T+1, with `busy`, `arr_en` and first feed visible in cycle T+1.
- A run with N vectors occupies N+5 RUN cycles. `done` asserts N+5 cycles after the RUN entry cycle.
- Back-to-back: a `start` asserted in the cycle after `done` is accepted.
- Reset asserted mid-RUN returns the state to IDLE immediately and zeroes `arr_en`/`arr_in`.
  - No `done` is produced. Results written so far remain.

## Configuration
- `NPU_SEQ_RELU_EN` defined: each captured value with bit 15 set (negative) is stored as 0.
- `NPU_SEQ_RELU_EN` undefined: raw 16-bit value stored unchanged.

## Structure
- Package `npu_pkg` holds:
  - constants `NPU_ROWS`=3, `NPU_COLS`=3, `NPU_IN_W`, `NPU_ACC_W`;
  - the capture offset constant `NPU_OUT_LAT`=3;
  - the state enum `npu_seq_state_t`.
- Sub-module `npu_skew`: computes the 3 skewed row bytes from `c` and the buffer read.
  - Keeps the skew indexing testable in isolation.

## Test plan
- Identity weights in bench array model, `nvec`=1, v0=(1,2,3) → `done` at RUN cycle 6; result[0..2]=1,2,3.
- `nvec`=2, weights all 1, v0=(1,1,1), v1=(2,3,4) → result[0..2]=3,3,3 and result[3..5]=9,9,9.
- `nvec`=0 `start` → no `busy`, no `done`. `nvec`=12 → run length 13 cycles (N=8).
- `start` and `vec_we` during RUN → no effect on results or timing. Buffer byte still holds the old value.
- Reset at RUN cycle 3 → `arr_en`=0 within the same cycle and state IDLE. A subsequent run completes normally.
- Weights −1, v0=(1,1,1) → result = 0xFFFD without `NPU_SEQ_RELU_EN`, and 0x0000 with it.

Source files
------------

// File: rtl/npu_pkg.sv
//==============================================================================
// npu_pkg : shared constants and state type for the NPU array sequencer.
// Revision: 1.0
//==============================================================================
`default_nettype none

package npu_pkg;

   localparam int NPU_ROWS    = 3;
   localparam int NPU_COLS    = 3;
   localparam int NPU_IN_W    = 8;
   localparam int NPU_ACC_W   = 16;
   localparam int NPU_OUT_LAT = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } npu_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/npu_skew.sv
//==============================================================================
// npu_skew : diagonal skew of buffered input vectors onto the array left edge.
// Revision: 1.0
//==============================================================================
`default_nettype none

module npu_skew
   import npu_pkg::*;
#(
   parameter int VDEPTH = 8,
   parameter int IN_W   = 8,
   parameter int CW     = 4
) (
   input  logic                     i_run,
   input  logic [CW-1:0]            i_cnt,
   input  logic [CW-1:0]            i_n,
   input  logic [NPU_ROWS*IN_W-1:0] i_vbuf [VDEPTH],
   output logic [NPU_ROWS*IN_W-1:0] o_row
);

   localparam int AW = $clog2(VDEPTH);

   // Row r lags row 0 by r cycles, so it sees vector (cnt - r).
   for (genvar r = 0; r < NPU_ROWS; r++) begin : g_row
      logic [CW-1:0]   w_k;
      logic            w_vld;
      logic [IN_W-1:0] w_byte;

      assign w_k    = i_cnt - CW'(r);
      assign w_vld  = i_run && (i_cnt >= CW'(r)) && (w_k < i_n);
      assign w_byte = i_vbuf[w_k[AW-1:0]][r*IN_W +: IN_W];
      assign o_row[r*IN_W +: IN_W] = w_vld ? w_byte : '0;
   end

endmodule

`default_nettype wire

// File: rtl/npu_seq.sv
//==============================================================================
// npu_seq : feeds the 3x3 systolic array from a vector buffer and captures
//           column results. Define NPU_SEQ_RELU_EN to store negatives as zero.
// Revision: 1.0
//==============================================================================
`default_nettype none

module npu_seq
   import npu_pkg::*;
#(
   parameter int VDEPTH = 8,
   parameter int IN_W   = 8,
   parameter int ACC_W  = 16
) (
   input  logic                              wb_clk_i,
   input  logic                              wb_rst_i,
   input  logic                              vec_we,
   input  logic [$clog2(VDEPTH)-1:0]         vec_waddr,
   input  logic [NPU_ROWS*IN_W-1:0]          vec_wdata,
   input  logic                              start,
   input  logic [3:0]                        nvec,
   output logic                              busy,
   output logic                              done,
   output logic                              arr_en,
   output logic [NPU_ROWS*IN_W-1:0]          arr_in,
   input  logic [NPU_COLS*ACC_W-1:0]         arr_o,
   input  logic [$clog2(NPU_COLS*VDEPTH)-1:0] res_raddr,
   output logic [ACC_W-1:0]                  res_rdata
);

   localparam int             CW    = $clog2(VDEPTH + 6);
   localparam int             RAW   = $clog2(NPU_COLS * VDEPTH);
   localparam logic [RAW:0]   RES_N = (RAW+1)'(NPU_COLS * VDEPTH);

   npu_seq_state_t            r_state;
   npu_seq_state_t            w_state_nx;
   logic [CW-1:0]             r_cnt;
   logic [CW-1:0]             r_n;
   logic [CW-1:0]             w_n_clamp;
   logic [NPU_ROWS*IN_W-1:0]  r_vbuf [VDEPTH];
   logic [ACC_W-1:0]          r_res  [NPU_COLS*VDEPTH];

   logic [NPU_COLS-1:0]       w_hit;
   logic [RAW-1:0]            w_waddr [NPU_COLS];
   logic [ACC_W-1:0]          w_wval  [NPU_COLS];

   always_comb begin
      if (int'(nvec) > VDEPTH) w_n_clamp = CW'(VDEPTH);
      else                     w_n_clamp = CW'(nvec);
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_n     <= '0;
      end else begin
         r_state <= w_state_nx;
         if (r_state == ST_RUN) r_cnt <= r_cnt + CW'(1);
         else                   r_cnt <= '0;
         if ((r_state == ST_IDLE) && start) r_n <= w_n_clamp;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      busy       = 1'b0;
      done       = 1'b0;
      arr_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && (nvec != 4'd0)) w_state_nx = ST_RUN;
         end
         ST_RUN: begin
            busy   = 1'b1;
            arr_en = 1'b1;
            if (r_cnt == r_n + CW'(4)) w_state_nx = ST_DONE;
         end
         ST_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            w_state_nx = ST_IDLE;
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (vec_we && (r_state == ST_IDLE)) r_vbuf[vec_waddr] <= vec_wdata;
   end

   npu_skew #(
      .VDEPTH (VDEPTH),
      .IN_W   (IN_W),
      .CW     (CW)
   ) u_skew (
      .i_run  (arr_en),
      .i_cnt  (r_cnt),
      .i_n    (r_n),
      .i_vbuf (r_vbuf),
      .o_row  (arr_in)
   );

   // Column j emerges j + NPU_OUT_LAT cycles after its vector enters row 0.
   for (genvar j = 0; j < NPU_COLS; j++) begin : g_col
      logic [CW-1:0]    w_k;
      logic [ACC_W-1:0] w_raw;

      assign w_k        = r_cnt - CW'(j + NPU_OUT_LAT);
      assign w_hit[j]   = (r_state == ST_RUN) && (r_cnt >= CW'(j + NPU_OUT_LAT)) && (w_k < r_n);
      assign w_waddr[j] = RAW'(w_k) * RAW'(NPU_COLS) + RAW'(j);
      assign w_raw      = arr_o[j*ACC_W +: ACC_W];
`ifdef NPU_SEQ_RELU_EN
      assign w_wval[j]  = w_raw[ACC_W-1] ? '0 : w_raw;
`else
      assign w_wval[j]  = w_raw;
`endif
   end

   always_ff @(posedge wb_clk_i) begin
      for (int j = 0; j < NPU_COLS; j++) begin
         if (w_hit[j]) r_res[w_waddr[j]] <= w_wval[j];
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i)                       res_rdata <= '0;
      else if ({1'b0, res_raddr} < RES_N) res_rdata <= r_res[res_raddr];
      else                                res_rdata <= '0;
   end

endmodule

`default_nettype wire

// File: tb/tb_npu_seq.sv
//==============================================================================
// tb_npu_seq : directed bench for npu_seq with a 3x3 array model driving arr_o.
// Revision: 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_npu_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vec_we = 1'b0;
   logic [2:0]  vec_waddr = '0;
   logic [23:0] vec_wdata = '0;
   logic        start = 1'b0;
   logic [3:0]  nvec = '0;
   logic        busy, done, arr_en;
   logic [23:0] arr_in;
   logic [47:0] arr_o = '0;
   logic [4:0]  res_raddr = '0;
   logic [15:0] res_rdata;

   always #5 clk = ~clk;

   npu_seq dut (
      .wb_clk_i  (clk),
      .wb_rst_i  (rst),
      .vec_we    (vec_we),
      .vec_waddr (vec_waddr),
      .vec_wdata (vec_wdata),
      .start     (start),
      .nvec      (nvec),
      .busy      (busy),
      .done      (done),
      .arr_en    (arr_en),
      .arr_in    (arr_in),
      .arr_o     (arr_o),
      .res_raddr (res_raddr),
      .res_rdata (res_rdata)
   );

   int n_checks = 0;
   int n_errs   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Array model: weight-stationary 3x3; row r activation reaches column j's
   // bottom output j+3-r cycles after it is presented on the left edge.
   int          W [3][3];
   logic [23:0] hist [0:8191];
   int          cyc = 0;

   always @(posedge clk) cyc = cyc + 1;

   always @(negedge clk) begin : p_array
      int s, d;
      logic [23:0] h;
      hist[cyc] = arr_in;
      for (int j = 0; j < 3; j++) begin
         s = 0;
         for (int r = 0; r < 3; r++) begin
            d = j + 3 - r;
            if (cyc - d >= 0) begin
               h = hist[cyc - d];
               s += W[r][j] * $signed(h[8*r +: 8]);
            end
         end
         arr_o[16*j +: 16] = s[15:0];
      end
   end

   // Reference model: timeline position within a run plus the matrix product.
   logic [23:0] m_vec [8];
   logic [15:0] m_res [24];
   bit          m_ok  [24];
   int          m_t = -1;
   int          m_n = 0;

   function automatic logic [15:0] dot(input int k, input int j);
      int s;
      logic [23:0] v;
      s = 0;
      v = m_vec[k];
      for (int r = 0; r < 3; r++) s += W[r][j] * $signed(v[8*r +: 8]);
`ifdef NPU_SEQ_RELU_EN
      if (s < 0) s = 0;
`endif
      return s[15:0];
   endfunction

   always @(posedge clk or posedge rst) begin : p_model
      int k;
      if (rst) begin
         m_t = -1;
      end else begin
         if (m_t >= 0 && m_t <= m_n + 4) begin
            for (int j = 0; j < 3; j++) begin
               k = m_t - j - 3;
               if (k >= 0 && k < m_n) begin
                  m_res[3*k + j] = dot(k, j);
                  m_ok[3*k + j]  = 1'b1;
               end
            end
         end
         if (m_t < 0 && vec_we) m_vec[vec_waddr] = vec_wdata;
         if (m_t < 0) begin
            if (start && nvec != 0) begin
               m_t = 0;
               m_n = (nvec > 8) ? 8 : int'(nvec);
            end
         end else if (m_t == m_n + 5) begin
            m_t = -1;
         end else begin
            m_t = m_t + 1;
         end
      end
   end

   always @(negedge clk) begin : p_cmp
      logic [23:0] e_in;
      logic [23:0] v;
      int k;
      bit running;
      running = (m_t >= 0) && (m_t <= m_n + 4);
      e_in = '0;
      if (running) begin
         for (int r = 0; r < 3; r++) begin
            k = m_t - r;
            if (k >= 0 && k < m_n) begin
               v = m_vec[k];
               e_in[8*r +: 8] = v[8*r +: 8];
            end
         end
      end
      chk("busy",   {31'd0, busy},   {31'd0, m_t >= 0});
      chk("done",   {31'd0, done},   {31'd0, m_t >= 0 && m_t == m_n + 5});
      chk("arr_en", {31'd0, arr_en}, {31'd0, running});
      chk("arr_in", {8'd0, arr_in},  {8'd0, e_in});
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr_vec(input int a, input logic [7:0] x0, input logic [7:0] x1, input logic [7:0] x2);
      vec_we    = 1'b1;
      vec_waddr = 3'(a);
      vec_wdata = {x2, x1, x0};
      tick();
      vec_we    = 1'b0;
   endtask

   task automatic launch(input int n);
      start = 1'b1;
      nvec  = 4'(n);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int en);
      lat = 0;
      en  = 0;
      while (!done && lat < 60) begin
         if (arr_en) en++;
         tick();
         lat++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
      tick();
   endtask

   task automatic rd(input int idx, output logic [15:0] v);
      res_raddr = 5'(idx);
      tick();
      v = res_rdata;
   endtask

   task automatic chk_res(input int idx, input logic [15:0] exp);
      logic [15:0] v;
      rd(idx, v);
      chk($sformatf("res[%0d]", idx), {16'd0, v}, {16'd0, exp});
      if (m_ok[idx]) chk($sformatf("res_model[%0d]", idx), {16'd0, v}, {16'd0, m_res[idx]});
   endtask

   task automatic set_w(input int mode);
      for (int r = 0; r < 3; r++)
         for (int j = 0; j < 3; j++)
            W[r][j] = (mode == 0) ? ((r == j) ? 1 : 0) : ((mode == 1) ? 1 : -1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : p_stim
      int lat, en, seen;
      logic [15:0] v;
      set_w(0);
      tick(2);
      chk("rst_busy",   {31'd0, busy},   32'd0);
      chk("rst_done",   {31'd0, done},   32'd0);
      chk("rst_arr_en", {31'd0, arr_en}, 32'd0);
      chk("rst_arr_in", {8'd0, arr_in},  32'd0);
      chk("rst_rdata",  {16'd0, res_rdata}, 32'd0);
      rst = 1'b0;
      tick();

      for (int k = 0; k < 8; k++) wr_vec(k, 8'(k), 8'(k + 1), 8'(k + 2));

      // Identity weights, one vector.
      wr_vec(0, 8'd1, 8'd2, 8'd3);
      launch(1);
      wait_done(lat, en);
      chk("t1_done_lat", lat, 6);
      chk_res(0, 16'd1);
      chk_res(1, 16'd2);
      chk_res(2, 16'd3);

      // All-ones weights, two vectors.
      set_w(1);
      wr_vec(0, 8'd1, 8'd1, 8'd1);
      wr_vec(1, 8'd2, 8'd3, 8'd4);
      launch(2);
      wait_done(lat, en);
      chk("t2_done_lat", lat, 7);
      for (int i = 0; i < 3; i++) chk_res(i, 16'd3);
      for (int i = 3; i < 6; i++) chk_res(i, 16'd9);

      // nvec = 0 never launches.
      launch(0);
      seen = 0;
      repeat (10) begin
         if (busy || done) seen++;
         tick();
      end
      chk("t3_nvec0_activity", seen, 0);

      // nvec = 12 clamps to 8.
      set_w(0);
      launch(12);
      wait_done(lat, en);
      chk("t4_run_len", en, 13);
      chk("t4_done_lat", lat, 13);
      chk_res(16, 16'd6);
      chk_res(23, 16'd9);
      for (int i = 0; i < 24; i++) begin
         rd(i, v);
         chk($sformatf("t4_res_model[%0d]", i), {16'd0, v}, {16'd0, m_res[i]});
      end

      // start and vec_we during RUN are ignored.
      set_w(1);
      launch(2);
      tick();
      start = 1'b1; nvec = 4'd1;
      vec_we = 1'b1; vec_waddr = 3'd0; vec_wdata = {8'd50, 8'd50, 8'd50};
      tick();
      start = 1'b0; vec_we = 1'b0;
      wait_done(lat, en);
      chk("t5_done_lat", lat + 2, 7);
      chk("t5_run_len", en + 2, 7);
      for (int i = 0; i < 3; i++) chk_res(i, 16'd3);
      for (int i = 3; i < 6; i++) chk_res(i, 16'd9);
      set_w(0);
      launch(1);
      wait_done(lat, en);
      chk_res(0, 16'd1);
      chk_res(1, 16'd1);

      // Reset at RUN cycle 3, then a normal run with weights of -1.
      set_w(1);
      launch(2);
      tick(3);
      #2 rst = 1'b1;
      #1;
      chk("t6_arr_en", {31'd0, arr_en}, 32'd0);
      chk("t6_busy",   {31'd0, busy},   32'd0);
      chk("t6_arr_in", {8'd0, arr_in},  32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick(2);

      set_w(2);
      launch(1);
      wait_done(lat, en);
      chk("t7_done_lat", lat, 6);
`ifdef NPU_SEQ_RELU_EN
      chk_res(0, 16'h0000);
      chk_res(2, 16'h0000);
`else
      chk_res(0, 16'hFFFD);
      chk_res(2, 16'hFFFD);
`endif

      tick(2);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
